key_debounce: RTL

Debounces the active-low DE-board pushbuttons (KEY) and converts each one into a clean active-high level plus one-cycle press and release pulses. It sits directly upstream of the switch-to-HEX display logic and replaces raw KEY sampling there. KEY-driven select and reset then see exactly one event per physical press, regardless of contact bounce.

---
 rtl/key_debounce_pkg.sv | 18 +
 rtl/key_debounce_ch.sv | 106 ++++++++++
 rtl/key_debounce.sv | 38 +++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg
// Shared types and constants for the pushbutton debouncer.
//   db_state_t    per-channel debounce FSM states
//   KEY_PRESSED   raw KEY level when a button is pushed (active-low)
//   KEY_RELEASED  raw KEY level when a button is idle
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } db_state_t;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
// One debounce channel: a two-flop synchronizer, a four-state FSM and a
// saturating stability counter. A change of the synchronized key is
// accepted only after it has held for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk            system clock
//   reset          synchronous, active-high
//   key            raw pushbutton, active-low, asynchronous to clk
//   level          debounced state, 1 = pressed (registered)
//   press_pulse    one-cycle pulse when a press is accepted (registered)
//   release_pulse  one-cycle pulse when a release is accepted (registered)
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_ff;
  logic          pressed;
  db_state_t     state;
  logic [CW-1:0] count;

  // Synchronizer resets to the idle raw level so a key held through reset
  // is seen as a fresh press once reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= {2{KEY_RELEASED}};
    end else begin
      sync_ff <= {sync_ff[0], key};
    end
  end

  assign pressed = (sync_ff[1] == KEY_PRESSED);

  // The WAIT states count cycles in which the new value has held; any
  // return to the old value abandons the attempt without a pulse. The
  // entry cycle into WAIT is the first stable sample, hence LAST = N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= UP;
      count         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        UP: begin
          if (pressed) begin
            state <= WAIT_DOWN;
            count <= '0;
          end
        end
        WAIT_DOWN: begin
          if (!pressed) begin
            state <= UP;
            count <= '0;
          end else if (count == LAST) begin
            state       <= DOWN;
            count       <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else if (count != MAX) begin
            count <= count + 1'b1;
          end
        end
        DOWN: begin
          if (!pressed) begin
            state <= WAIT_UP;
            count <= '0;
          end
        end
        WAIT_UP: begin
          if (pressed) begin
            state <= DOWN;
            count <= '0;
          end else if (count == LAST) begin
            state         <= UP;
            count         <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else if (count != MAX) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= UP;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// key_debounce
// Debounces the active-low DE-board pushbuttons into clean active-high
// levels plus one-cycle press/release pulses. Channels are independent.
// Ports:
//   CLOCK_50     system clock, the only clock
//   reset        synchronous, active-high
//   KEY          raw pushbuttons [N_KEYS], active-low, asynchronous
//   key_level    debounced state [N_KEYS], 1 = pressed
//   key_press    one-cycle press pulse per key
//   key_release  one-cycle release pulse per key
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (CLOCK_50),
      .reset        (reset),
      .key          (KEY[i]),
      .level        (key_level[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i])
    );
  end

endmodule
